// File: rtl/cpu_dma_tx_watchdog_pkg.sv
// rtl/cpu_dma_tx_watchdog_pkg.sv - shared states, defaults and width helper for the CPU DMA TX watchdog
package cpu_dma_tx_watchdog_pkg;

    localparam int DEFAULT_TX_WATCHDOG_TIMEOUT = 125000;
    localparam int DEFAULT_FLUSH_CYCLES        = 16;

    typedef enum logic [1:0] {
        CPU_DMA_WD_IDLE   = 2'd0,
        CPU_DMA_WD_ACTIVE = 2'd1,
        CPU_DMA_WD_FLUSH  = 2'd2
    } wd_state_t;

    // Bits needed to hold values 0 .. value-1 (ceil log2), never less than 1.
    function automatic int log2(input int value);
        int bits;
        bits = 1;
        for (int i = 1; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/cpu_dma_tx_watchdog_if.sv
// rtl/cpu_dma_tx_watchdog_if.sv - DMA TX handshake and watchdog status bundle
// Optional max-stall signals exist only with CPU_DMA_TX_WD_MAX_STALL_EN defined.
interface cpu_dma_tx_watchdog_if
    import cpu_dma_tx_watchdog_pkg::*;
#(
    parameter int CNT_WIDTH = log2(DEFAULT_TX_WATCHDOG_TIMEOUT + 1)
);
    logic                 wd_enable;
    logic                 dma_tx_start;
    logic                 dma_tx_data_vld;
    logic                 dma_tx_eop;
    logic                 tx_timeout;
    logic                 tx_flush;
    logic                 tx_busy;
    logic [CNT_WIDTH-1:0] stall_cnt;
`ifdef CPU_DMA_TX_WD_MAX_STALL_EN
    logic                 max_stall_clr;
    logic [CNT_WIDTH-1:0] max_stall;

    modport master (
        output wd_enable, dma_tx_start, dma_tx_data_vld, dma_tx_eop, max_stall_clr,
        input  tx_timeout, tx_flush, tx_busy, stall_cnt, max_stall
    );
    modport slave (
        input  wd_enable, dma_tx_start, dma_tx_data_vld, dma_tx_eop, max_stall_clr,
        output tx_timeout, tx_flush, tx_busy, stall_cnt, max_stall
    );
`else
    modport master (
        output wd_enable, dma_tx_start, dma_tx_data_vld, dma_tx_eop,
        input  tx_timeout, tx_flush, tx_busy, stall_cnt
    );
    modport slave (
        input  wd_enable, dma_tx_start, dma_tx_data_vld, dma_tx_eop,
        output tx_timeout, tx_flush, tx_busy, stall_cnt
    );
`endif
endinterface

// File: rtl/cpu_dma_wd_counter.sv
// rtl/cpu_dma_wd_counter.sv - saturating up-counter with clear priority and terminal-count flag
module cpu_dma_wd_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_VAL)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == MAX_VAL);

endmodule

// File: rtl/cpu_dma_tx_watchdog.sv
// rtl/cpu_dma_tx_watchdog.sv - per-queue CPU DMA TX stall watchdog with timeout pulse and flush window
// Define CPU_DMA_TX_WD_MAX_STALL_EN to add the max_stall tracker and its clear input.
module cpu_dma_tx_watchdog
    import cpu_dma_tx_watchdog_pkg::*;
#(
    parameter int TX_WATCHDOG_TIMEOUT = DEFAULT_TX_WATCHDOG_TIMEOUT,
    parameter int FLUSH_CYCLES        = DEFAULT_FLUSH_CYCLES
) (
    input logic                  clk,
    input logic                  reset_n,
    cpu_dma_tx_watchdog_if.slave bus
);
    localparam int CNT_WIDTH  = log2(TX_WATCHDOG_TIMEOUT + 1);
    localparam int FCNT_WIDTH = log2(FLUSH_CYCLES + 1);

    wd_state_t             state;
    wd_state_t             state_nxt;
    logic [CNT_WIDTH-1:0]  stall_cnt;
    logic                  stall_tc;
    logic                  stall_clr;
    logic [FCNT_WIDTH-1:0] flush_cnt_unused;
    logic                  flush_tc;
    logic                  timeout_nxt;
    logic                  timeout_q;
    logic                  flush_q;
    logic                  busy_q;

    cpu_dma_wd_counter #(.WIDTH(CNT_WIDTH), .MAX(TX_WATCHDOG_TIMEOUT - 1)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (stall_clr),
        .inc     (1'b1),
        .cnt     (stall_cnt),
        .tc      (stall_tc)
    );

    // Runs only while in FLUSH; its terminal count ends the flush window.
    cpu_dma_wd_counter #(.WIDTH(FCNT_WIDTH), .MAX(FLUSH_CYCLES - 1)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state != CPU_DMA_WD_FLUSH),
        .inc     (1'b1),
        .cnt     (flush_cnt_unused),
        .tc      (flush_tc)
    );

    always_comb begin
        state_nxt   = state;
        stall_clr   = 1'b1;
        timeout_nxt = 1'b0;
        case (state)
            CPU_DMA_WD_IDLE: begin
                if (bus.dma_tx_start && bus.dma_tx_data_vld && bus.wd_enable && !bus.dma_tx_eop) begin
                    state_nxt = CPU_DMA_WD_ACTIVE;
                end
            end
            CPU_DMA_WD_ACTIVE: begin
                // Enable loss and eop end tracking; any word or restart keeps the counter cleared.
                if (!bus.wd_enable || (bus.dma_tx_data_vld && bus.dma_tx_eop)) begin
                    state_nxt = CPU_DMA_WD_IDLE;
                end else if (!(bus.dma_tx_data_vld || bus.dma_tx_start)) begin
                    if (stall_tc) begin
                        state_nxt   = CPU_DMA_WD_FLUSH;
                        timeout_nxt = 1'b1;
                    end else begin
                        stall_clr = 1'b0;
                    end
                end
            end
            CPU_DMA_WD_FLUSH: begin
                if (flush_tc) begin
                    state_nxt = CPU_DMA_WD_IDLE;
                end
            end
            default: state_nxt = CPU_DMA_WD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CPU_DMA_WD_IDLE;
            timeout_q <= 1'b0;
            flush_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            timeout_q <= timeout_nxt;
            flush_q   <= (state_nxt == CPU_DMA_WD_FLUSH);
            busy_q    <= (state_nxt == CPU_DMA_WD_ACTIVE);
        end
    end

    assign bus.tx_timeout = timeout_q;
    assign bus.tx_flush   = flush_q;
    assign bus.tx_busy    = busy_q;
    assign bus.stall_cnt  = stall_cnt;

`ifdef CPU_DMA_TX_WD_MAX_STALL_EN
    logic [CNT_WIDTH-1:0] max_stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            max_stall_q <= '0;
        end else if (bus.max_stall_clr) begin
            max_stall_q <= '0;
        end else if ((state == CPU_DMA_WD_ACTIVE) && (stall_cnt > max_stall_q)) begin
            max_stall_q <= stall_cnt;
        end
    end

    assign bus.max_stall = max_stall_q;
`endif

endmodule

// File: tb/tb_cpu_dma_tx_watchdog.sv
// tb/tb_cpu_dma_tx_watchdog.sv - directed and randomized checks of cpu_dma_tx_watchdog against a packet-level model
module tb_cpu_dma_tx_watchdog;
    import cpu_dma_tx_watchdog_pkg::*;

    localparam int T  = 16;
    localparam int F  = 4;
    localparam int CW = log2(T + 1);

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cpu_dma_tx_watchdog_if #(.CNT_WIDTH(CW)) bus ();

    cpu_dma_tx_watchdog #(.TX_WATCHDOG_TIMEOUT(T), .FLUSH_CYCLES(F)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: in a packet or not, cycles since the last accepted word, flush cycles still owed.
    bit m_pkt;
    int m_gap;
    int m_flush_left;
    bit m_to;
    int m_max;
    bit en_v;
    bit clr_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pkt = 0; m_gap = 0; m_flush_left = 0; m_to = 0; m_max = 0;
    endtask

    task automatic model_step(input bit st, input bit vld, input bit eop, input bit en, input bit clr);
        bit pkt_before;
        int gap_before;
        pkt_before = m_pkt;
        gap_before = m_gap;
        m_to = 0;
        if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (m_pkt) begin
            if (!en || (vld && eop)) begin
                m_pkt = 0; m_gap = 0;
            end else if (vld || st) begin
                m_gap = 0;
            end else if (m_gap + 1 == T) begin
                m_to = 1; m_pkt = 0; m_gap = 0; m_flush_left = F;
            end else begin
                m_gap++;
            end
        end else if (st && vld && en && !eop) begin
            m_pkt = 1; m_gap = 0;
        end
        if (clr) m_max = 0;
        else if (pkt_before && gap_before > m_max) m_max = gap_before;
    endtask

    task automatic check_all();
        check("tx_timeout", 32'(bus.tx_timeout), 32'(m_to));
        check("tx_flush",   32'(bus.tx_flush),   32'(m_flush_left > 0));
        check("tx_busy",    32'(bus.tx_busy),    32'(m_pkt));
        check("stall_cnt",  32'(bus.stall_cnt),  32'(m_gap));
`ifdef CPU_DMA_TX_WD_MAX_STALL_EN
        check("max_stall",  32'(bus.max_stall),  32'(m_max));
`endif
    endtask

    task automatic cyc(input bit st, input bit vld, input bit eop);
        bus.wd_enable       = en_v;
        bus.dma_tx_start    = st;
        bus.dma_tx_data_vld = vld;
        bus.dma_tx_eop      = eop;
`ifdef CPU_DMA_TX_WD_MAX_STALL_EN
        bus.max_stall_clr   = clr_v;
`endif
        @(posedge clk);
        model_step(st, vld, eop, en_v, clr_v);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    initial begin
        int lat;
        int flen;
        int peak;
        int pct;
        en_v = 1; clr_v = 0;
        bus.wd_enable = 1; bus.dma_tx_start = 0; bus.dma_tx_data_vld = 0; bus.dma_tx_eop = 0;
`ifdef CPU_DMA_TX_WD_MAX_STALL_EN
        bus.max_stall_clr = 0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset_n = 1;

        // Normal packet: 5 words with a 3-cycle gap.
        peak = 0;
        cyc(1, 1, 0); cyc(0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            if (int'(bus.stall_cnt) > peak) peak = int'(bus.stall_cnt);
        end
        cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 1, 1);
        check("normal_peak", 32'(peak), 32'd3);
        idle(2);

        // Stall: timeout latency and flush length.
        cyc(1, 1, 0); cyc(0, 1, 0);
        lat = 41;
        for (int i = 1; i <= 40; i++) begin
            cyc(0, 0, 0);
            if (bus.tx_timeout) begin lat = i; break; end
        end
        check("timeout_latency", 32'(lat), 32'(T));
        flen = 1;
        for (int i = 0; i < 20 && bus.tx_flush; i++) begin
            cyc(1, 1, 0);
            if (bus.tx_flush) flen++;
        end
        check("flush_length", 32'(flen), 32'(F));
        cyc(1, 1, 0);
        cyc(0, 1, 1);
        idle(1);

        // Race: word on the terminal-count cycle wins.
        cyc(1, 1, 0);
        idle(T - 1);
        check("race_terminal", 32'(bus.stall_cnt), 32'(T - 1));
        cyc(0, 1, 0);
        idle(4);
        cyc(0, 1, 1);

        // Single-word packet and restart while active.
        cyc(1, 1, 1);
        idle(3);
        cyc(1, 1, 0); idle(5); cyc(1, 1, 0); idle(T - 2); cyc(0, 1, 1);

        // Enable dropped mid-packet.
        cyc(1, 1, 0); idle(10);
        en_v = 0; cyc(0, 0, 0);
        en_v = 1; idle(T + 2);

        // Async reset during the timeout/flush cycle.
        cyc(1, 1, 0);
        for (int i = 0; i < 40 && !bus.tx_timeout; i++) cyc(0, 0, 0);
        #3 reset_n = 0;
        #1;
        model_reset();
        check("rst_timeout", 32'(bus.tx_timeout), 32'd0);
        check("rst_flush",   32'(bus.tx_flush),   32'd0);
        #2 reset_n = 1;
        idle(2);

`ifdef CPU_DMA_TX_WD_MAX_STALL_EN
        cyc(1, 1, 0); idle(3); cyc(0, 1, 0); idle(7); cyc(0, 1, 0); idle(2); cyc(0, 1, 1);
        idle(1);
        check("max_stall_7", 32'(bus.max_stall), 32'd7);
        clr_v = 1; cyc(0, 0, 0); clr_v = 0;
        check("max_stall_clr", 32'(bus.max_stall), 32'd0);
        cyc(1, 1, 0); idle(2);
        clr_v = 1; cyc(0, 0, 0); clr_v = 0;
        check("max_stall_clr_wins", 32'(bus.max_stall), 32'd0);
        cyc(0, 1, 1);
`endif

        // Randomized traffic with bursty data rates.
        pct = 40;
        for (int i = 0; i < 3000; i++) begin
            bit st, vld, eop;
            if (i % 32 == 0) begin
                case ($urandom_range(0, 2))
                    0: pct = 5;
                    1: pct = 40;
                    default: pct = 90;
                endcase
            end
            en_v  = ($urandom_range(0, 199) != 0);
            clr_v = ($urandom_range(0, 99) == 0);
            st    = ($urandom_range(0, 7) == 0);
            vld   = ($urandom_range(0, 99) < pct);
            eop   = vld && ($urandom_range(0, 4) == 0);
            cyc(st, vld, eop);
        end
        en_v = 1; clr_v = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
